// File: rtl/sysid_pkg.sv
// sysid_pkg: shared FSM state type and word offsets for the system-ID checker.
package sysid_pkg;
    typedef enum logic [2:0] {IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, CHECK, DONE} state_t;
    localparam int ID_WORD_OFS = 0;
    localparam int TS_WORD_OFS = 1;
    localparam int AVM_DATA_W = 32;
endpackage

// File: rtl/avm_single_read.sv
// avm_single_read: issues one Avalon-MM read per go pulse, with waitrequest stall, optional pipelined data and a timeout.
// Ports: clock/reset (async, active-high); go/addr start a read; avm_* bus signals;
// accept = bus accepted the read, capture = data valid this cycle, expire = timeout this cycle; data = read word.
module avm_single_read
    import sysid_pkg::*;
#(
    parameter int ADDR_W = 1,
    parameter int RST_ADDR = 0,
    parameter int PIPELINED = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  go,
    input  logic [ADDR_W-1:0]     addr,
    output logic [ADDR_W-1:0]     avm_address,
    output logic                  avm_read,
    input  logic                  avm_waitrequest,
    input  logic [AVM_DATA_W-1:0] avm_readdata,
    input  logic                  avm_readdatavalid,
    output logic                  accept,
    output logic                  capture,
    output logic                  expire,
    output logic [AVM_DATA_W-1:0] data
);
    localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);
    logic        active;
    logic [15:0] cnt;
    assign accept = avm_read && !avm_waitrequest;
    // Pipelined data only counts once the request phase is over (read dropped while still active).
    assign capture = (PIPELINED != 0) ? active && !avm_read && avm_readdatavalid : accept;
    // Capture in the final allowed cycle beats expiry.
    assign expire = active && cnt == LAST && !capture;
    assign data = avm_readdata;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            active      <= 1'b0;
            avm_read    <= 1'b0;
            avm_address <= ADDR_W'(RST_ADDR);
            cnt         <= '0;
        end else if (go) begin
            active      <= 1'b1;
            avm_read    <= 1'b1;
            avm_address <= addr;
            cnt         <= '0;
        end else if (active) begin
            cnt <= cnt + 16'd1;
            if (capture || expire) begin
                active   <= 1'b0;
                avm_read <= 1'b0;
            end else if (accept) begin
                avm_read <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/sysid_checker.sv
// sysid_checker: on start, reads the system-ID and timestamp words and reports match or timeout status.
// Ports: clock/reset (async, active-high); start request; avm_* Avalon-MM read master;
// busy/done handshake; id_ok/ts_ok match flags; timeout sticky error; read_id/read_ts captured words.
module sysid_checker
    import sysid_pkg::*;
#(
    parameter int          ADDR_W = 1,
    parameter int          BASE_ADDR = 0,
    parameter logic [31:0] EXPECTED_ID = 32'h0,
    parameter logic [31:0] EXPECTED_TS = 32'h0,
    parameter int          PIPELINED = 0,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic [ADDR_W-1:0]     avm_address,
    output logic                  avm_read,
    input  logic                  avm_waitrequest,
    input  logic [AVM_DATA_W-1:0] avm_readdata,
    input  logic                  avm_readdatavalid,
    output logic                  busy,
    output logic                  done,
    output logic                  id_ok,
    output logic                  ts_ok,
    output logic                  timeout,
    output logic [AVM_DATA_W-1:0] read_id,
    output logic [AVM_DATA_W-1:0] read_ts
);
    state_t                state, next;
    logic                  go, accept, capture, expire, in_id, in_ts;
    logic [ADDR_W-1:0]     rd_addr;
    logic [AVM_DATA_W-1:0] data;
    assign in_id = state == ID_REQ || state == ID_WAIT;
    assign in_ts = state == TS_REQ || state == TS_WAIT;
    always_comb begin
        next = state;
        case (state)
            IDLE:             next = (start && !timeout) ? ID_REQ : IDLE;
            ID_REQ, ID_WAIT:  next = capture ? TS_REQ : expire ? DONE : accept ? ID_WAIT : state;
            TS_REQ, TS_WAIT:  next = capture ? CHECK : expire ? DONE : accept ? TS_WAIT : state;
            CHECK:            next = DONE;
            default:          next = IDLE;
        endcase
    end
    // A new read is launched on entry to either request state; the timestamp read follows the ID capture directly.
    assign go = (state == IDLE && next == ID_REQ) || (in_id && next == TS_REQ);
    assign rd_addr = ADDR_W'(BASE_ADDR + (in_id ? TS_WORD_OFS : ID_WORD_OFS));
    avm_single_read #(
        .ADDR_W(ADDR_W),
        .RST_ADDR(BASE_ADDR),
        .PIPELINED(PIPELINED),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_read (
        .clock(clock),
        .reset(reset),
        .go(go),
        .addr(rd_addr),
        .avm_address(avm_address),
        .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .accept(accept),
        .capture(capture),
        .expire(expire),
        .data(data)
    );
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            id_ok   <= 1'b0;
            ts_ok   <= 1'b0;
            timeout <= 1'b0;
            read_id <= '0;
            read_ts <= '0;
        end else begin
            state <= next;
            busy  <= next != IDLE;
            done  <= next == DONE;
            // Results from the previous check stay visible until a new check is accepted.
            if (state == IDLE && next == ID_REQ) begin
                id_ok   <= 1'b0;
                ts_ok   <= 1'b0;
                read_id <= '0;
                read_ts <= '0;
            end
            if (capture && in_id) read_id <= data;
            if (capture && in_ts) read_ts <= data;
            if (state == CHECK) begin
                id_ok <= read_id == EXPECTED_ID;
                ts_ok <= read_ts == EXPECTED_TS;
            end
            if (expire) timeout <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sysid_checker.sv
// tb_sysid_checker: randomized check of two checker instances (zero-latency and pipelined slave) against a timing model.
module tb_sysid_checker;
    localparam int          T = 8;
    localparam int          BASE = 2;
    localparam logic [31:0] EXP_ID = 32'h51D0_C0DE;
    localparam logic [31:0] EXP_TS = 32'h6612_3400;
    logic        clk = 1'b0;
    logic        rst;
    logic        start[2], wr[2], rdv[2], rd[2], busy[2], done[2], id_ok[2], ts_ok[2], tmo[2];
    logic [1:0]  addr[2];
    logic [31:0] rdata[2], rid[2], rts[2];
    int          n_chk = 0;
    int          n_fail = 0;
    always #5 clk = ~clk;
    for (genvar g = 0; g < 2; g++) begin : g_dut
        sysid_checker #(
            .ADDR_W(2),
            .BASE_ADDR(BASE),
            .EXPECTED_ID(EXP_ID),
            .EXPECTED_TS(EXP_TS),
            .PIPELINED(g),
            .TIMEOUT_CYCLES(T)
        ) dut (
            .clock(clk),
            .reset(rst),
            .start(start[g]),
            .avm_address(addr[g]),
            .avm_read(rd[g]),
            .avm_waitrequest(wr[g]),
            .avm_readdata(rdata[g]),
            .avm_readdatavalid(rdv[g]),
            .busy(busy[g]),
            .done(done[g]),
            .id_ok(id_ok[g]),
            .ts_ok(ts_ok[g]),
            .timeout(tmo[g]),
            .read_id(rid[g]),
            .read_ts(rts[g])
        );
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask
    // One check on instance p: slave stalls w0/w1 cycles per read, pipelined data arrives lat cycles after accept.
    task automatic run(input int p, input int w0, input int w1, input int lat, input logic [31:0] d0, input logic [31:0] d1);
        int          ws[2];
        logic [31:0] wd[2];
        int          t0, t1, dc, rh, hi, nacc, stall, pend;
        logic        to, acc;
        logic [31:0] eid, ets;
        bit          seen;
        ws[0] = w0; ws[1] = w1; wd[0] = d0; wd[1] = d1;
        // Cycles from first read assertion to capture, for each word.
        t0 = w0 + 1 + (p == 1 ? lat : 0);
        t1 = w1 + 1 + (p == 1 ? lat : 0);
        to = t0 > T || t1 > T;
        eid = t0 <= T ? d0 : 32'h0;
        ets = to ? 32'h0 : d1;
        // Cycle (start cycle = 1) in which done is high.
        dc = t0 > T ? T + 2 : t1 > T ? t0 + T + 2 : t0 + t1 + 3;
        rh = (w0 + 1 < T ? w0 + 1 : T) + (t0 <= T ? (w1 + 1 < T ? w1 + 1 : T) : 0);
        nacc = 0; stall = 0; pend = 0; hi = 0; seen = 0;
        for (int cyc = 1; cyc <= 200 && !seen; cyc++) begin
            @(negedge clk);
            chk("busy", busy[p], cyc > 1);
            chk("single_outstanding", rd[p] && pend > 0, 0);
            if (done[p]) begin
                seen = 1;
                chk("done_cycle", cyc, dc);
                start[p] = 1'b0;
                rdv[p] = 1'b0;
            end else begin
                start[p] = cyc == 1 || $urandom_range(0, 4) == 0;
                rdata[p] = $urandom;
                acc = 1'b0;
                if (rd[p]) begin
                    chk("addr", addr[p], BASE + nacc);
                    hi++;
                    wr[p] = nacc > 1 || stall < ws[nacc];
                    stall++;
                    acc = !wr[p];
                end else begin
                    wr[p] = $urandom_range(0, 1) == 1;
                end
                if (pend > 0) begin
                    pend--;
                    rdv[p] = pend == 0;
                    if (pend == 0) rdata[p] = wd[nacc-1];
                end else begin
                    rdv[p] = p == 1 && !acc && $urandom_range(0, 3) == 0;
                end
                if (acc) begin
                    if (p == 0) rdata[p] = wd[nacc];
                    else pend = lat;
                    nacc++;
                    stall = 0;
                end
            end
        end
        chk("done_seen", seen, 1);
        chk("timeout", tmo[p], to);
        chk("id_ok", id_ok[p], !to && d0 == EXP_ID);
        chk("ts_ok", ts_ok[p], !to && d1 == EXP_TS);
        chk("read_id", rid[p], eid);
        chk("read_ts", rts[p], ets);
        chk("read_cycles", hi, rh);
        @(negedge clk);
        chk("done_pulse", done[p], 0);
        chk("busy_after", busy[p], 0);
        if (to) begin
            start[p] = 1'b1;
            @(negedge clk);
            start[p] = 1'b0;
            repeat (3) begin
                @(negedge clk);
                chk("start_blocked", busy[p], 0);
            end
            chk("timeout_sticky", tmo[p], 1);
            do_reset();
        end
    endtask
    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0; wr[i] = 1'b1; rdv[i] = 1'b0; rdata[i] = 32'h0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_read", rd[i], 0);
            chk("rst_addr", addr[i], BASE);
            chk("rst_busy", busy[i], 0);
            chk("rst_done", done[i], 0);
            chk("rst_ok", {id_ok[i], ts_ok[i], tmo[i]}, 0);
            chk("rst_words", rid[i] | rts[i], 0);
        end
        rst = 1'b0;
        @(negedge clk);
        run(0, 0, 0, 1, EXP_ID, EXP_TS);
        run(0, 3, 3, 1, EXP_ID, EXP_TS);
        run(1, 0, 0, 2, EXP_ID, 32'h1234_5678);
        run(0, 1000, 0, 1, EXP_ID, EXP_TS);
        // Reset while the ID request is stalled: read must drop without waiting for a clock edge.
        start[1] = 1'b1; wr[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        @(negedge clk);
        chk("req_read", rd[1], 1);
        rst = 1'b1;
        #1;
        chk("async_req_read", rd[1], 0);
        chk("async_req_busy", busy[1], 0);
        @(negedge clk);
        rst = 1'b0;
        // Reset during ID_WAIT, then a late data strobe.
        start[1] = 1'b1; wr[1] = 1'b0;
        @(negedge clk);
        start[1] = 1'b0;
        @(negedge clk);
        chk("wait_busy", busy[1], 1);
        chk("wait_read", rd[1], 0);
        rst = 1'b1;
        #1;
        chk("async_wait_read", rd[1], 0);
        chk("async_wait_busy", busy[1], 0);
        @(negedge clk);
        rst = 1'b0; rdv[1] = 1'b1; rdata[1] = EXP_ID;
        @(negedge clk);
        rdv[1] = 1'b0;
        chk("late_rdv_busy", busy[1], 0);
        chk("late_rdv_id", rid[1], 0);
        chk("late_rdv_done", done[1], 0);
        run(1, 1, 1, 1, EXP_ID, EXP_TS);
        for (int k = 0; k < 40; k++) begin
            int          p, w0, w1, lat;
            logic [31:0] d0, d1;
            p = $urandom_range(0, 1);
            w0 = $urandom_range(0, 9) == 0 ? 1000 : $urandom_range(0, 4);
            w1 = $urandom_range(0, 9) == 0 ? 1000 : $urandom_range(0, 4);
            lat = $urandom_range(1, 4);
            d0 = $urandom_range(0, 1) == 1 ? EXP_ID : $urandom;
            d1 = $urandom_range(0, 1) == 1 ? EXP_TS : $urandom;
            run(p, w0, w1, lat, d0, d1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sysid_checker.md
Name: sysid_checker

Overview:
- Avalon-MM read master sitting directly upstream of the system-ID slave; consumes its 32-bit readdata.
- On a start pulse, reads word 0 (system ID) and then word 1 (build timestamp) from that slave.
- Compares both words against build-time expected values and reports pass, fail or timeout status to boot/status logic (LEDs, CPU status register).

Parameters:
- ADDR_W, 1, width of avm_address (word address).
- BASE_ADDR, 0, word address of the ID word; the timestamp word is at BASE_ADDR+1.
- EXPECTED_ID, 32'h0, required system ID value.
- EXPECTED_TS, 32'h0, required timestamp value.
- PIPELINED, 0:
  - 0: readdata is captured in the accept cycle (zero-latency slave).
  - 1: readdata is captured when avm_readdatavalid is asserted.
- TIMEOUT_CYCLES, 255, maximum cycles per read, counted from first read assertion to data capture; range 1..65535.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to run a check.
- avm_address  out  ADDR_W  word address of the current read.
- avm_read  out  1  Avalon read strobe.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  32  slave data.
- avm_readdatavalid  in  1  data-valid strobe; used only when PIPELINED=1.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.
- id_ok  out  1  captured ID equals EXPECTED_ID.
- ts_ok  out  1  captured timestamp equals EXPECTED_TS.
- timeout  out  1  sticky error flag.
- read_id  out  32  captured ID word.
- read_ts  out  32  captured timestamp word.

Behaviour:
- Reset state:
  - State is IDLE.
  - avm_read=0, avm_address=BASE_ADDR, busy=0, done=0, id_ok=0, ts_ok=0, timeout=0, read_id=0, read_ts=0, timeout counter=0.
  - Reset asserted mid-operation drops avm_read asynchronously; no partial results are retained.
- FSM states: IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, CHECK, DONE. All outputs are registered.
- IDLE:
  - start=1 and timeout=0: next state ID_REQ.
  - Clears id_ok, ts_ok, read_id and read_ts.
  - start is ignored in every other state, and also while timeout=1.
- ID_REQ:
  - avm_read=1, avm_address=BASE_ADDR; both held stable while avm_waitrequest=1.
  - Accept condition: avm_read & !avm_waitrequest.
  - PIPELINED=0: capture read_id on the accept cycle, then go to TS_REQ.
  - PIPELINED=1: go to ID_WAIT with avm_read=0 from the next cycle.
- ID_WAIT: capture read_id on the first avm_readdatavalid=1 cycle, then go to TS_REQ. Only one read is ever outstanding.
- TS_REQ / TS_WAIT: identical to ID_REQ / ID_WAIT, using address BASE_ADDR+1 and capturing read_ts; exit to CHECK.
- CHECK (one cycle): id_ok <= (read_id==EXPECTED_ID); ts_ok <= (read_ts==EXPECTED_TS).
- DONE (one cycle): done=1, busy=0 on the next cycle, return to IDLE.
  - id_ok, ts_ok, read_id and read_ts hold their values until the next accepted start.
- Timeout:
  - The counter resets on entry to each REQ state and increments every cycle in REQ/WAIT.
  - When it reaches TIMEOUT_CYCLES without capture: timeout=1 (sticky), avm_read=0, go to DONE with id_ok=ts_ok=0.
  - timeout clears only on reset.
- Data filtering:
  - avm_readdatavalid outside a WAIT state is ignored.
  - avm_readdatavalid during a REQ state before acceptance is ignored.
- Simultaneous events:
  - Capture and counter expiry in the same cycle: capture wins and no timeout is raised.
  - start together with the DONE cycle: start is ignored.
- Latency with a zero-wait slave: PIPELINED=0 gives start to done = 5 cycles (ID_REQ, TS_REQ, CHECK, DONE, plus the IDLE exit).

Decomposition:
- Shared package sysid_pkg:
  - state enum for the FSM.
  - localparams ID_WORD_OFS=0 and TS_WORD_OFS=1.
  - AVM_DATA_W=32.
- One natural sub-module: avm_single_read.
  - Issues one Avalon read with waitrequest, PIPELINED and timeout handling.
  - Returns data plus a valid or timeout pulse.
  - Instantiated once; the top FSM sequences the two reads.

Test Plan:
- Zero-wait, PIPELINED=0, slave returns EXPECTED_ID / EXPECTED_TS -> addresses 0 then 1; done pulses 5 cycles after start; id_ok=1, ts_ok=1, timeout=0.
- avm_waitrequest held 3 cycles on each read -> address and read stay stable during the stall; done arrives 6 cycles later than the zero-wait case; results correct.
- PIPELINED=1, readdatavalid 2 cycles after accept, timestamp word wrong (e.g. 32'h1234_5678) -> id_ok=1, ts_ok=0, read_ts=32'h1234_5678.
- Slave never deasserts waitrequest, TIMEOUT_CYCLES=8 -> avm_read drops after 8 cycles; timeout=1, done pulses; a subsequent start is ignored.
- Reset asserted during ID_WAIT -> avm_read=0 and busy=0 immediately; a late readdatavalid is ignored; a fresh start completes normally.
- Stray readdatavalid in IDLE, plus a start pulse during busy -> no state change; exactly one done pulse per accepted start.
